line_sensor_frontend: RTL and testbench

Drives and times an array of RC-decay reflectance line sensors, then thresholds and filters the results. Produces the stable per-channel line-detect vector that feeds the line-detect PIO input port, which the Avalon CPU reads. It sits between the top-level bidirectional sensor pins and that PIO. A frame is charge, then measure decay time, then update outputs, repeated while enabled.

---
 rtl/line_sensor_frontend.sv | 146 ++++++++++++++
 tb/tb_line_sensor_frontend.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/line_sensor_frontend.sv
// RC-decay reflectance sensor front end: charges the sensor pins, times each
// channel's decay, thresholds the times and debounces the line-detect vector.
module line_sensor_frontend #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned CNT_W          = 18,
  parameter int unsigned CHARGE_CYCLES  = 500,
  parameter int unsigned TIMEOUT_CYCLES = 150000,
  parameter int unsigned THRESHOLD      = 50000,
  parameter int unsigned FILTER_SAMPLES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [N_CH-1:0]       sensor_in,
  output logic                  sensor_oe,
  output logic [N_CH-1:0]       line_out,
  output logic [N_CH*CNT_W-1:0] raw_time,
  output logic                  frame_done
);

  localparam int unsigned       FILT_W       = $clog2(FILTER_SAMPLES + 1);
  localparam logic [CNT_W-1:0]  CHARGE_LAST  = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  THRESH_VAL   = CNT_W'(THRESHOLD);
  localparam logic [FILT_W-1:0] FILT_LAST    = FILT_W'(FILTER_SAMPLES);

  // Parameter sanity: every count must fit the shared counter.
  if (TIMEOUT_CYCLES >= (64'd1 << CNT_W)) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES must be below 2**CNT_W");
  end
  if (THRESHOLD >= (64'd1 << CNT_W)) begin : g_chk_threshold
    $error("THRESHOLD must be below 2**CNT_W");
  end
  if ((CHARGE_CYCLES < 1) || (CHARGE_CYCLES >= (64'd1 << CNT_W))) begin : g_chk_charge
    $error("CHARGE_CYCLES must be in 1 .. 2**CNT_W-1");
  end
  if (FILTER_SAMPLES < 1) begin : g_chk_filter
    $error("FILTER_SAMPLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, CHARGE, MEASURE, UPDATE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_CH-1:0]         done_q, done_d;
  logic [CNT_W-1:0]        decay_q [N_CH];
  logic [CNT_W-1:0]        decay_d [N_CH];
  logic [FILT_W-1:0]       filt_q  [N_CH];
  logic [FILT_W-1:0]       filt_d  [N_CH];
  logic [N_CH-1:0]         sync1_q, sync2_q;
  logic [N_CH-1:0]         line_d;
  logic [N_CH*CNT_W-1:0]   raw_d;

  // Next-state, capture, timeout fill and filter; results are published on entry to UPDATE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    decay_d = decay_q;
    filt_d  = filt_q;
    line_d  = line_out;
    raw_d   = raw_time;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = CHARGE;
      end
      CHARGE: begin
        if (cnt_q == CHARGE_LAST) begin
          state_d = MEASURE;
          cnt_d   = '0;
          done_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEASURE: begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (!done_q[i] && !sync2_q[i]) begin
            decay_d[i] = cnt_q;
            done_d[i]  = 1'b1;
          end
        end
        if (&done_d) begin
          state_d = UPDATE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = UPDATE;
          for (int unsigned i = 0; i < N_CH; i++) begin
            if (!done_d[i]) decay_d[i] = TIMEOUT_VAL;
          end
        end
        if (state_d == UPDATE) begin
          for (int unsigned i = 0; i < N_CH; i++) begin
            raw_d[i*CNT_W +: CNT_W] = decay_d[i];
            if ((decay_d[i] >= THRESH_VAL) == line_out[i]) begin
              filt_d[i] = '0;
            end else if ((filt_q[i] + FILT_W'(1)) == FILT_LAST) begin
              line_d[i] = ~line_out[i];
              filt_d[i] = '0;
            end else begin
              filt_d[i] = filt_q[i] + FILT_W'(1);
            end
          end
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= '0;
      decay_q    <= '{default: '0};
      filt_q     <= '{default: '0};
      sync1_q    <= '0;
      sync2_q    <= '0;
      sensor_oe  <= 1'b0;
      line_out   <= '0;
      raw_time   <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      decay_q    <= decay_d;
      filt_q     <= filt_d;
      sync1_q    <= sensor_in;
      sync2_q    <= sync1_q;
      sensor_oe  <= (state_d == CHARGE);
      line_out   <= line_d;
      raw_time   <= raw_d;
      frame_done <= (state_d == UPDATE);
    end
  end

endmodule

// File: tb/tb_line_sensor_frontend.sv
// Directed bench for line_sensor_frontend with an RC-decay pin model.
module tb_line_sensor_frontend;

  localparam int N_CH  = 4;
  localparam int CNT_W = 18;
  localparam int NEVER = 100000;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  enable = 1'b0;
  logic [N_CH-1:0]       sensor_in;
  logic                  sensor_oe;
  logic [N_CH-1:0]       line_out;
  logic [N_CH*CNT_W-1:0] raw_time;
  logic                  frame_done;

  int dly [N_CH];
  int mc;
  logic            toggle_mode = 1'b0;
  logic [N_CH-1:0] toggle_val = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  line_sensor_frontend #(
    .N_CH(N_CH), .CNT_W(CNT_W), .CHARGE_CYCLES(4), .TIMEOUT_CYCLES(100),
    .THRESHOLD(40), .FILTER_SAMPLES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sensor_in(sensor_in),
    .sensor_oe(sensor_oe), .line_out(line_out), .raw_time(raw_time),
    .frame_done(frame_done)
  );

  // Cycles since sensor_oe fell; pin i reads low once this reaches dly[i].
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)        mc <= 0;
    else if (sensor_oe)  mc <= 0;
    else if (mc < NEVER) mc <= mc + 1;
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++)
      sensor_in[i] = toggle_mode ? toggle_val[i] : (sensor_oe | (mc < dly[i]));
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_raw(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [N_CH];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < N_CH; i++)
      check($sformatf("%s_ch%0d", tag, i), 128'(raw_time[i*CNT_W +: CNT_W]), 128'(e[i]));
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    dly = '{d0, d1, d2, d3};
  endtask

  // Waits for a frame_done pulse; cyc = negedges consumed.
  task automatic wait_frame(input int max_cyc, output int cyc);
    cyc = 0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (frame_done) return;
    end
    check("frame_seen", 128'(frame_done), 128'(1));
  endtask

  task automatic wait_oe(input logic lvl, input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (sensor_oe == lvl) return;
    end
    check("oe_level", 128'(sensor_oe), 128'(lvl));
  endtask

  initial begin
    int cyc, hi, rise_cyc, pulses, oe_seen;
    set_dly(10, 37, 38, NEVER);

    // Reset held with toggling pins
    enable = 1'b1;
    toggle_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      toggle_val = ~toggle_val ^ 4'(k);
    end
    check("rst_oe", 128'(sensor_oe), 128'(0));
    check("rst_line", 128'(line_out), 128'(0));
    check("rst_raw", 128'(raw_time), 128'(0));
    check("rst_done", 128'(frame_done), 128'(0));
    toggle_mode = 1'b0;
    reset_n = 1'b1;

    // Cycle 1 is the IDLE cycle ending at the first edge after release
    rise_cyc = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rise_cyc++;
      if (sensor_oe) break;
    end
    check("oe_rise_cycle", 128'(rise_cyc), 128'(2));
    hi = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!sensor_oe) break;
      hi++;
    end
    check("oe_high_cycles", 128'(hi), 128'(4));

    // Threshold and timeout, three frames
    for (int f = 1; f <= 3; f++) begin
      wait_frame(300, cyc);
      check_raw($sformatf("thr_f%0d", f), 12, 39, 40, 100);
      check($sformatf("thr_line_f%0d", f), 128'(line_out), 128'((f == 3) ? 4'b1100 : 4'b0000));
      @(negedge clk);
      check("done_one_cycle", 128'(frame_done), 128'(0));
    end

    // Filter glitch on ch1
    set_dly(10, 60, 38, NEVER);
    wait_frame(300, cyc);
    check("glitch_raw1", 128'(raw_time[CNT_W +: CNT_W]), 128'(62));
    check("glitch_line_a", 128'(line_out), 128'(4'b1100));
    set_dly(10, 37, 38, NEVER);
    wait_frame(300, cyc);
    check("glitch_line_b", 128'(line_out), 128'(4'b1100));
    set_dly(10, 60, 38, NEVER);
    wait_frame(300, cyc);
    check("glitch_line_c", 128'(line_out), 128'(4'b1100));
    wait_frame(300, cyc);
    check("glitch_line_d", 128'(line_out), 128'(4'b1100));
    wait_frame(300, cyc);
    check("glitch_line_e", 128'(line_out), 128'(4'b1110));

    // Early exit, all channels decay at D=5
    set_dly(5, 5, 5, 5);
    wait_oe(1'b1, 20);
    wait_oe(1'b0, 20);
    wait_frame(50, cyc);
    check("early_latency", 128'(cyc), 128'(8));
    check_raw("early", 7, 7, 7, 7);
    check("early_line", 128'(line_out), 128'(4'b1110));
    wait_frame(50, cyc);
    check("early_period", 128'(cyc), 128'(14));

    // Enable dropped mid-MEASURE; third disagreement on ch1 flips it
    set_dly(10, 37, 38, NEVER);
    wait_oe(1'b1, 20);
    wait_oe(1'b0, 20);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_frame(300, cyc);
    check("drop_line", 128'(line_out), 128'(4'b1100));
    check_raw("drop", 12, 39, 40, 100);
    pulses = 0;
    oe_seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (frame_done) pulses++;
      if (sensor_oe) oe_seen++;
    end
    check("drop_extra_done", 128'(pulses), 128'(0));
    check("drop_oe_quiet", 128'(oe_seen), 128'(0));
    enable = 1'b1;
    @(negedge clk);
    check("reenable_charge", 128'(sensor_oe), 128'(1));

    // Asynchronous reset mid-CHARGE
    #2 reset_n = 1'b0;
    #1;
    check("areset_oe", 128'(sensor_oe), 128'(0));
    check("areset_line", 128'(line_out), 128'(0));
    check("areset_raw", 128'(raw_time), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    wait_frame(300, cyc);
    check_raw("post_reset", 12, 39, 40, 100);
    check("post_reset_line", 128'(line_out), 128'(4'b0000));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
